booth_multiplier_seq: RTL and testbench

- Iterative multi-cycle radix-2 Booth multiplier. It performs one add/subtract-and-shift step per clock.
- Parametrised operand width. A per-operation mode selects signed (two's complement) or unsigned multiplication.
- Uses a start/busy/done handshake and a registered product. It sits in the datapath as a small-area multiply unit for sequential controllers.

---
 rtl/booth_multiplier_seq_if.sv | 16 +
 rtl/booth_multiplier_seq.sv | 83 ++++++++
 tb/tb_booth_multiplier_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/booth_multiplier_seq_if.sv
// Request/response bundle for the sequential Booth multiplier.
// The requester holds the master side and the multiplier holds the slave side.
interface booth_multiplier_seq_if #(
  parameter int NR_BITS = 4
);
  logic                   start;
  logic                   is_signed;
  logic [NR_BITS-1:0]     M;
  logic [NR_BITS-1:0]     R;
  logic                   busy;
  logic                   done;
  logic [2*NR_BITS-1:0]   out;

  modport master (output start, is_signed, M, R, input busy, done, out);
  modport slave  (input start, is_signed, M, R, output busy, done, out);
endinterface

// File: rtl/booth_multiplier_seq.sv
// Iterative radix-2 Booth multiplier: one add/sub-and-shift step per clock.
// Supports signed and unsigned operands. The product register changes only on completion.
module booth_multiplier_seq #(
  parameter int NR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  booth_multiplier_seq_if.slave bus
);
  localparam int PW = 2*NR_BITS + 3;
  localparam int EW = NR_BITS + 1;
  localparam int CW = $clog2(NR_BITS + 2);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        p_q, p_d, a_q, a_d, p_sum, p_shr;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*NR_BITS-1:0] out_q, out_d;
  logic [EW-1:0]        m_ext, r_ext;

  // An extra top bit lets unsigned operands go through the signed Booth recoding.
  always_comb begin
    m_ext = bus.is_signed ? {bus.M[NR_BITS-1], bus.M} : {1'b0, bus.M};
    r_ext = bus.is_signed ? {bus.R[NR_BITS-1], bus.R} : {1'b0, bus.R};
  end

  always_comb begin
    case (p_q[1:0])
      2'b01:   p_sum = p_q + a_q;
      2'b10:   p_sum = p_q - a_q;
      default: p_sum = p_q;
    endcase
    p_shr = {p_sum[PW-1], p_sum[PW-1:1]};
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      RUN: begin
        p_d   = p_shr;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d   = p_shr[2*NR_BITS:1];
          state_d = FINISH;
        end
      end
      default: begin
        state_d = IDLE;
        if (bus.start) begin
          p_d     = {{EW{1'b0}}, r_ext, 1'b0};
          a_d     = {m_ext, {(NR_BITS+2){1'b0}}};
          cnt_d   = CW'(NR_BITS + 1);
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == FINISH);
  assign bus.out  = out_q;
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench: directed NR_BITS=4 cases plus a random NR_BITS=8 sweep.
// The reference is plain integer multiplication.
module tb_booth_multiplier_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  booth_multiplier_seq_if #(.NR_BITS(4)) b4 ();
  booth_multiplier_seq_if #(.NR_BITS(8)) b8 ();

  booth_multiplier_seq #(.NR_BITS(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));
  booth_multiplier_seq #(.NR_BITS(8)) dut8 (.clk(clk), .reset(reset), .bus(b8.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_mul(input int n, input bit sgn,
                                           input logic [31:0] m, input logic [31:0] r);
    longint a, b, p;
    a = longint'(m);
    b = longint'(r);
    if (sgn && m[n-1]) a = a - (longint'(1) << n);
    if (sgn && r[n-1]) b = b - (longint'(1) << n);
    p = a * b;
    return 64'(p) & ((64'd1 << (2*n)) - 64'd1);
  endfunction

  // Starts one 4-bit operation and checks busy, done and latency cycle by cycle.
  task automatic run4(input string tag, input bit sgn, input logic [3:0] m,
                      input logic [3:0] r, input logic [7:0] exp);
    b4.is_signed = sgn; b4.M = m; b4.R = r; b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    repeat (5) begin
      chk({tag, "_busy"}, 64'(b4.busy), 64'd1);
      chk({tag, "_nodone"}, 64'(b4.done), 64'd0);
      tick();
    end
    chk({tag, "_done"}, 64'(b4.done), 64'd1);
    chk({tag, "_busy_lo"}, 64'(b4.busy), 64'd0);
    chk({tag, "_out"}, 64'(b4.out), 64'(exp));
    tick();
  endtask

  initial begin
    int cyc;
    logic [7:0] m8, r8;
    bit s8;
    b4.start = 0; b4.is_signed = 0; b4.M = '0; b4.R = '0;
    b8.start = 0; b8.is_signed = 0; b8.M = '0; b8.R = '0;

    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("rst_busy", 64'(b4.busy), 64'd0);
      chk("rst_done", 64'(b4.done), 64'd0);
      chk("rst_out", 64'(b4.out), 64'd0);
      tick();
    end
    chk("rst_out8", 64'(b8.out), 64'd0);

    // -3 * 5 signed, then the result must hold with done low.
    run4("s_m3x5", 1'b1, 4'hD, 4'h5, 8'hF1);
    chk("hold_done", 64'(b4.done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_out", 64'(b4.out), 64'hF1);
      tick();
    end
    run4("u_13x5", 1'b0, 4'hD, 4'h5, 8'h41);
    run4("u_15x15", 1'b0, 4'hF, 4'hF, 8'hE1);
    run4("s_m8xm8", 1'b1, 4'h8, 4'h8, 8'h40);
    run4("s_0x7", 1'b1, 4'h0, 4'h7, 8'h00);

    // Hold start high; operands churn during RUN and must not disturb the result.
    b4.is_signed = 0; b4.M = 4'd3; b4.R = 4'd4; b4.start = 1'b1;
    tick();
    cyc = 0;
    while (!b4.done && cyc < 20) begin
      b4.M = 4'($urandom); b4.R = 4'($urandom); b4.is_signed = 1'($urandom);
      tick(); cyc++;
    end
    chk("b2b_lat1", 64'(cyc), 64'd5);
    chk("b2b_out1", 64'(b4.out), 64'h0C);
    b4.is_signed = 1; b4.M = 4'hF; b4.R = 4'hF;
    tick();
    cyc = 1;
    while (!b4.done && cyc < 20) begin
      chk("b2b_busy", 64'(b4.busy), 64'd1);
      b4.M = 4'($urandom); b4.R = 4'($urandom); b4.is_signed = 1'($urandom);
      tick(); cyc++;
    end
    chk("b2b_spacing", 64'(cyc), 64'd6);
    chk("b2b_out2", 64'(b4.out), 64'h01);
    b4.start = 1'b0;
    tick();
    chk("b2b_idle_done", 64'(b4.done), 64'd0);
    chk("b2b_idle_out", 64'(b4.out), 64'h01);

    // Abort at step 2 with a one-cycle reset.
    b4.is_signed = 0; b4.M = 4'd7; b4.R = 4'd9; b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("abort_done", 64'(b4.done), 64'd0);
      chk("abort_busy", 64'(b4.busy), 64'd0);
      chk("abort_out", 64'(b4.out), 64'd0);
      tick();
    end
    run4("post_abort", 1'b0, 4'd7, 4'd9, 8'd63);

    // Random sweep on the 8-bit instance.
    for (int k = 0; k < 500; k++) begin
      m8 = 8'($urandom); r8 = 8'($urandom); s8 = 1'($urandom);
      case ($urandom_range(0, 7))
        0: m8 = 8'h80;
        1: r8 = 8'hFF;
        default: ;
      endcase
      b8.M = m8; b8.R = r8; b8.is_signed = s8; b8.start = 1'b1;
      tick();
      b8.start = 1'b0;
      cyc = 0;
      while (!b8.done && cyc < 40) begin
        if ($urandom_range(0, 3) == 0) b8.start = 1'b1;
        b8.M = 8'($urandom); b8.R = 8'($urandom); b8.is_signed = 1'($urandom);
        tick(); cyc++;
        b8.start = 1'b0;
      end
      chk("rnd_lat", 64'(cyc), 64'd9);
      chk("rnd_out", 64'(b8.out), ref_mul(8, s8, 32'(m8), 32'(r8)));
      repeat ($urandom_range(1, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
